// File: rtl/orb_fast_pkg.sv
// Shared types and constants for the FAST-N corner detector: FSM states and the r=3 Bresenham circle.
package orb_fast_pkg;

  localparam int CIRCLE_PTS = 16;
  localparam int BORDER     = 3;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    FETCH,
    DRAIN,
    EVAL,
    WRITE,
    DONE
  } state_t;

  // Index 0 is straight up (0,-3), walking clockwise with y growing downward.
  function automatic logic signed [3:0] circ_dx(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd8:        circ_dx = 4'sd0;
      4'd1, 4'd7:        circ_dx = 4'sd1;
      4'd2, 4'd6:        circ_dx = 4'sd2;
      4'd3, 4'd4, 4'd5:  circ_dx = 4'sd3;
      4'd9, 4'd15:       circ_dx = -4'sd1;
      4'd10, 4'd14:      circ_dx = -4'sd2;
      default:           circ_dx = -4'sd3;
    endcase
  endfunction

  function automatic logic signed [3:0] circ_dy(input logic [3:0] idx);
    case (idx)
      4'd4, 4'd12:       circ_dy = 4'sd0;
      4'd5, 4'd11:       circ_dy = 4'sd1;
      4'd6, 4'd10:       circ_dy = 4'sd2;
      4'd3, 4'd13:       circ_dy = -4'sd1;
      4'd2, 4'd14:       circ_dy = -4'sd2;
      4'd0, 4'd1, 4'd15: circ_dy = -4'sd3;
      default:           circ_dy = 4'sd3;
    endcase
  endfunction

endpackage

// File: rtl/fast_arc_check.sv
// Flags a circular run of at least ARC_LEN set bits in a 16-bit circle mask (run may wrap 15->0).
module fast_arc_check
  import orb_fast_pkg::*;
#(
  parameter int ARC_LEN = 9
) (
  input  logic [CIRCLE_PTS-1:0] i_mask,
  output logic                  o_hit
);

  logic [2*CIRCLE_PTS-1:0] w_dup;

  // Doubling the mask turns every wrapping run into a plain window.
  assign w_dup = {i_mask, i_mask};

  always_comb begin
    o_hit = 1'b0;
    for (int s = 0; s < CIRCLE_PTS; s++) begin
      o_hit = o_hit | (&w_dup[s +: ARC_LEN]);
    end
  end

endmodule

// File: rtl/orb_fast_detect_param.sv
// FAST-N corner detector: raster-scans CONV_RAM and writes a 1-bit corner map to FAST_RAM.
// Defining FAST_COUNT_EN adds a corner_count output holding the number of corners in the last frame.
module orb_fast_detect_param
  import orb_fast_pkg::*;
#(
  parameter int X_MAX       = 400,
  parameter int Y_MAX       = 400,
  parameter int PIXEL_DEPTH = 8,
  parameter int ARC_LEN     = 9
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         start,
  input  logic [$clog2(X_MAX):0]       img_w,
  input  logic [$clog2(Y_MAX):0]       img_h,
  input  logic [PIXEL_DEPTH-1:0]       threshold,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(X_MAX):0]       x_addr,
  output logic [$clog2(Y_MAX):0]       y_addr,
  output logic                         ren,
  input  logic [PIXEL_DEPTH-1:0]       rdat,
  output logic [$clog2(X_MAX):0]       x_addr_fast,
  output logic [$clog2(Y_MAX):0]       y_addr_fast,
  output logic                         wen_fast,
  output logic                         wdat_fast
`ifdef FAST_COUNT_EN
  ,
  output logic [$clog2(X_MAX*Y_MAX):0] corner_count
`endif
);

  localparam int XW  = $clog2(X_MAX) + 1;
  localparam int YW  = $clog2(Y_MAX) + 1;
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam int PW1 = PIXEL_DEPTH + 1;

  state_t                 r_state, w_next;
  logic [XW-1:0]          r_w, r_x, w_nx, w_ax;
  logic [YW-1:0]          r_h, r_y, w_ny, w_ay;
  logic [PIXEL_DEPTH-1:0] r_t, r_centre;
  logic [PIXEL_DEPTH-1:0] r_circ [CIRCLE_PTS];
  logic [4:0]             r_idx, r_rd_idx;
  logic                   r_rd_vld, r_corner;
  logic signed [3:0]      w_dx, w_dy;
  logic                   w_last_x, w_last, w_cur_border, w_nxt_border;
  logic [CIRCLE_PTS-1:0]  w_bright, w_dark;
  logic                   w_hit_b, w_hit_d;

  function automatic logic is_border(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                     input logic [XW-1:0] w, input logic [YW-1:0] h);
    is_border = (x < XW'(BORDER)) || (y < YW'(BORDER)) ||
                (({1'b0, x} + XW1'(BORDER)) >= {1'b0, w}) ||
                (({1'b0, y} + YW1'(BORDER)) >= {1'b0, h});
  endfunction

  assign w_last_x     = (r_x == r_w - XW'(1));
  assign w_last       = w_last_x && (r_y == r_h - YW'(1));
  assign w_nx         = w_last_x ? '0 : r_x + XW'(1);
  assign w_ny         = w_last_x ? r_y + YW'(1) : r_y;
  assign w_cur_border = is_border(r_x, r_y, r_w, r_h);
  assign w_nxt_border = is_border(w_nx, w_ny, r_w, r_h);

  // Read slot 0 is the centre; slot k (1..16) is circle point k-1. Interior pixels never leave the image.
  assign w_dx = (r_idx == 5'd0) ? 4'sd0 : circ_dx(r_idx[3:0] - 4'd1);
  assign w_dy = (r_idx == 5'd0) ? 4'sd0 : circ_dy(r_idx[3:0] - 4'd1);
  assign w_ax = r_x + XW'(w_dx);
  assign w_ay = r_y + YW'(w_dy);

  // Comparisons carry one extra bit so c+t and p+t never wrap.
  always_comb begin
    w_bright = '0;
    w_dark   = '0;
    for (int i = 0; i < CIRCLE_PTS; i++) begin
      w_bright[i] = PW1'(r_circ[i]) > (PW1'(r_centre) + PW1'(r_t));
      w_dark[i]   = (PW1'(r_circ[i]) + PW1'(r_t)) < PW1'(r_centre);
    end
  end

  fast_arc_check #(.ARC_LEN(ARC_LEN)) u_arc_bright (.i_mask(w_bright), .o_hit(w_hit_b));
  fast_arc_check #(.ARC_LEN(ARC_LEN)) u_arc_dark   (.i_mask(w_dark),   .o_hit(w_hit_d));

  // CONV_RAM read handshake: ren with x_addr/y_addr in cycle k, rdat is taken at the end of cycle k+1.
  always_comb begin
    w_next      = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    ren         = 1'b0;
    wen_fast    = 1'b0;
    wdat_fast   = 1'b0;
    x_addr      = '0;
    y_addr      = '0;
    x_addr_fast = '0;
    y_addr_fast = '0;
    case (r_state)
      IDLE: if (start) w_next = SCAN;
      SCAN: begin
        busy   = 1'b1;
        w_next = is_border('0, '0, r_w, r_h) ? WRITE : FETCH;
      end
      FETCH: begin
        busy   = 1'b1;
        ren    = 1'b1;
        x_addr = w_ax;
        y_addr = w_ay;
        if (r_idx == 5'd16) w_next = DRAIN;
      end
      DRAIN: begin
        busy   = 1'b1;
        w_next = EVAL;
      end
      EVAL: begin
        busy   = 1'b1;
        w_next = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        wen_fast    = 1'b1;
        wdat_fast   = r_corner & ~w_cur_border;
        x_addr_fast = r_x;
        y_addr_fast = r_y;
        if (w_last) w_next = DONE;
        else        w_next = w_nxt_border ? WRITE : FETCH;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_w      <= '0;
      r_h      <= '0;
      r_t      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_idx    <= '0;
      r_rd_idx <= '0;
      r_rd_vld <= 1'b0;
      r_centre <= '0;
      r_corner <= 1'b0;
      for (int i = 0; i < CIRCLE_PTS; i++) r_circ[i] <= '0;
    end else begin
      r_state  <= w_next;
      r_idx    <= (r_state == FETCH) ? r_idx + 5'd1 : 5'd0;
      r_rd_vld <= (r_state == FETCH);
      r_rd_idx <= r_idx;
      if (r_rd_vld) begin
        if (r_rd_idx == 5'd0) r_centre <= rdat;
        else                  r_circ[r_rd_idx[3:0] - 4'd1] <= rdat;
      end
      if (r_state == IDLE && start) begin
        r_w <= img_w;
        r_h <= img_h;
        r_t <= threshold;
        r_x <= '0;
        r_y <= '0;
      end
      if (r_state == WRITE && !w_last) begin
        r_x <= w_nx;
        r_y <= w_ny;
      end
      if (r_state == EVAL) r_corner <= w_hit_b | w_hit_d;
    end
  end

`ifdef FAST_COUNT_EN
  localparam int CW = $clog2(X_MAX*Y_MAX) + 1;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                         r_count <= '0;
    else if (r_state == IDLE && start)  r_count <= '0;
    else if (wen_fast && wdat_fast)     r_count <= r_count + CW'(1);
  end

  assign corner_count = r_count;
`endif

endmodule

// File: tb/tb_orb_fast_detect_param.sv
// Directed bench for orb_fast_detect_param: CONV_RAM model, write scoreboard, per-frame checks.
module tb_orb_fast_detect_param;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  img_w = '0;
  logic [9:0]  img_h = '0;
  logic [7:0]  threshold = '0;
  logic        busy, done, ren, wen_fast, wdat_fast;
  logic [9:0]  x_addr, y_addr, x_addr_fast, y_addr_fast;
  logic [7:0]  rdat = '0;
`ifdef FAST_COUNT_EN
  logic [18:0] corner_count;
`endif

  always #5 clk = ~clk;

  orb_fast_detect_param dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .img_w       (img_w),
    .img_h       (img_h),
    .threshold   (threshold),
    .busy        (busy),
    .done        (done),
    .x_addr      (x_addr),
    .y_addr      (y_addr),
    .ren         (ren),
    .rdat        (rdat),
    .x_addr_fast (x_addr_fast),
    .y_addr_fast (y_addr_fast),
    .wen_fast    (wen_fast),
    .wdat_fast   (wdat_fast)
`ifdef FAST_COUNT_EN
    ,
    .corner_count(corner_count)
`endif
  );

  logic [7:0]  mem [16][16];
  logic [20:0] exp_q[$];
  logic [20:0] exp_e;
  int cdx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int cdy [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};
  int n_tests = 0;
  int n_fail  = 0;
  int wr_total, wr_bad, wr_ones, overlap, rd_oob, snap;

  // CONV_RAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (ren) begin
      if (x_addr < 10'd16 && y_addr < 10'd16) rdat <= mem[y_addr[3:0]][x_addr[3:0]];
      else begin
        rdat   <= 8'h00;
        rd_oob = rd_oob + 1;
      end
    end
  end

  // FAST_RAM scoreboard: each write must match the next expected {y, x, bit} in raster order.
  always @(negedge clk) begin
    if (ren && wen_fast) overlap = overlap + 1;
    if (wen_fast) begin
      wr_total = wr_total + 1;
      if (wdat_fast) wr_ones = wr_ones + 1;
      if (exp_q.size() == 0) wr_bad = wr_bad + 1;
      else begin
        exp_e = exp_q.pop_front();
        if ({y_addr_fast, x_addr_fast, wdat_fast} !== exp_e) wr_bad = wr_bad + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int v);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) mem[y][x] = 8'(v);
  endtask

  task automatic set_arc(input int cx, input int cy, input int first, input int n, input int v);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (first + k) % 16;
      mem[cy + cdy[i]][cx + cdx[i]] = 8'(v);
    end
  endtask

  task automatic build_exp(input int w, input int h, input int cx, input int cy);
    exp_q.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        exp_q.push_back({10'(y), 10'(x), (x == cx && y == cy)});
  endtask

  task automatic run_frame(input string tag, input int w, input int h, input int t,
                           input int exp_cyc, input int exp_ones, input bit poke);
    int cyc;
    bit got;
    wr_total = 0; wr_bad = 0; wr_ones = 0; overlap = 0; rd_oob = 0;
    @(negedge clk);
    img_w = 10'(w); img_h = 10'(h); threshold = 8'(t); start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0; got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) cyc++;
      if (poke && i == 50) begin
        start = 1'b1; img_w = 10'd7; img_h = 10'd7; threshold = 8'd0;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_write_count"}, 64'(wr_total), 64'(w * h));
    check({tag, "_write_mismatch"}, 64'(wr_bad), 64'd0);
    check({tag, "_missing_writes"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_corner_writes"}, 64'(wr_ones), 64'(exp_ones));
    check({tag, "_ren_wen_overlap"}, 64'(overlap), 64'd0);
    check({tag, "_read_out_of_image"}, 64'(rd_oob), 64'd0);
`ifdef FAST_COUNT_EN
    check({tag, "_corner_count"}, 64'(corner_count), 64'(exp_ones));
`endif
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    wr_total = 0; wr_bad = 0; wr_ones = 0; overlap = 0; rd_oob = 0; snap = 0;
    fill(0);
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({busy, done, ren, wen_fast, wdat_fast,
                                x_addr, y_addr, x_addr_fast, y_addr_fast}), 64'd0);
    n_rst = 1'b1;

    // 16x16: 156 border pixels at 1 cycle, 100 interior at 20, plus the SCAN cycle.
    fill(100); build_exp(16, 16, -1, -1);
    run_frame("flat16", 16, 16, 10, 2157, 0, 1'b0);

    fill(50); mem[8][8] = 8'd200; build_exp(16, 16, 8, 8);
    run_frame("spot16", 16, 16, 20, 2157, 1, 1'b0);

    // 7x7 frames: single interior pixel (3,3); 48 border + 20 + 1 busy cycles.
    fill(100); set_arc(3, 3, 0, 9, 130); build_exp(7, 7, 3, 3);
    run_frame("arc9_bright", 7, 7, 20, 69, 1, 1'b0);

    fill(100); set_arc(3, 3, 0, 8, 130); build_exp(7, 7, -1, -1);
    run_frame("arc8_bright", 7, 7, 20, 69, 0, 1'b0);

    fill(100); set_arc(3, 3, 12, 9, 70); build_exp(7, 7, 3, 3);
    run_frame("wrap9_dark", 7, 7, 20, 69, 1, 1'b0);

    fill(100); set_arc(3, 3, 12, 8, 70); build_exp(7, 7, -1, -1);
    run_frame("wrap8_dark", 7, 7, 20, 69, 0, 1'b0);

    fill(250); set_arc(3, 3, 0, 16, 255); build_exp(7, 7, -1, -1);
    run_frame("no_wrap_bright", 7, 7, 10, 69, 0, 1'b0);

    fill(5); set_arc(3, 3, 0, 16, 0); build_exp(7, 7, -1, -1);
    run_frame("no_wrap_dark", 7, 7, 10, 69, 0, 1'b0);

    fill(240); set_arc(3, 3, 0, 16, 255); build_exp(7, 7, 3, 3);
    run_frame("high_bright", 7, 7, 10, 69, 1, 1'b0);

    fill(100); set_arc(3, 3, 0, 16, 120); build_exp(7, 7, -1, -1);
    run_frame("equal_bright", 7, 7, 20, 69, 0, 1'b0);

    fill(100); set_arc(3, 3, 0, 16, 80); build_exp(7, 7, -1, -1);
    run_frame("equal_dark", 7, 7, 20, 69, 0, 1'b0);

    // Abort a frame with reset partway through the interior.
    fill(100); build_exp(16, 16, -1, -1);
    @(negedge clk);
    img_w = 10'd16; img_h = 10'd16; threshold = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    check("midframe_busy", 64'(busy), 64'd1);
    n_rst = 1'b0;
    #1;
    check("midframe_reset_outputs", 64'({busy, done, ren, wen_fast, wdat_fast,
                                         x_addr, y_addr, x_addr_fast, y_addr_fast}), 64'd0);
    snap = wr_total;
    repeat (5) @(negedge clk);
    check("reset_write_delta", 64'(wr_total - snap), 64'd0);
    check("reset_busy_held", 64'(busy), 64'd0);
    n_rst = 1'b1;

    fill(50); mem[8][8] = 8'd200; build_exp(16, 16, 8, 8);
    run_frame("restart_with_start_poke", 16, 16, 20, 2157, 1, 1'b1);

    fill(50); mem[8][8] = 8'd200; build_exp(6, 16, -1, -1);
    run_frame("narrow6", 6, 16, 20, 97, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
